wb_arbiter_rr: RTL
==================

# wb_arbiter_rr

Parametrised N-master Wishbone bus arbiter. It grants one master at a time access to the shared slave bus and forwards only that master's cycle request. Arbitration is either fixed priority or round-robin. An optional ack-count hold limit forces a busy master to release the bus when others are waiting. It sits between the CPU, VGA and DMA masters and the shared SDRAM/peripheral interconnect.

## Interface
Parameters:
- NUM_MASTERS, 4: number of requesting masters, 2..16.
- RR_MODE, 1: 1 = round-robin; 0 = fixed priority, index 0 highest.
- HOLD_LIMIT, 0: maximum ack_i pulses per grant before forced release when another master is waiting; 0 = unlimited. Range 0..255.
- Derived: IDXW = max(1, clog2(NUM_MASTERS)).

Ports:
- clk_i  in  1  system clock; all state changes on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- cyc_i  in  NUM_MASTERS  per-master Wishbone cycle request.
- ack_i  in  1  slave acknowledge from the shared bus.
- cyc_o  out  1  cycle to the shared bus: cyc_i[gnt_idx_o] while granted, else 0. Combinational.
- gnt_o  out  NUM_MASTERS  one-hot grant, registered; all-zero when idle.
- gnt_idx_o  out  IDXW  index of the granted master, registered; holds the last value when idle.
- busy_o  out  1  1 while in GRANT.

## Operation
- State machine with two states.
  - IDLE: gnt_o = 0, cyc_o = 0.
  - GRANT: exactly one gnt_o bit is set.
- IDLE -> GRANT when any cyc_i bit is 1. The winner is chosen from the cyc_i value sampled at that edge.
- GRANT -> IDLE when either of these holds:
  - cyc_i[gnt_idx_o] = 0; or
  - hold limit reached: HOLD_LIMIT > 0, ack_i = 1, ack count + 1 >= HOLD_LIMIT, and any other cyc_i bit = 1.
- GRANT never goes directly to GRANT for another master. Every release passes through at least one IDLE cycle, which gives one cycle of bus turnaround.
- Winner selection:
  - Fixed priority (RR_MODE = 0): lowest set index wins.
  - Round-robin (RR_MODE = 1): first set index scanning from last+1 upward, wrapping modulo NUM_MASTERS.
  - last is a register updated to the winner on each IDLE -> GRANT. It resets to NUM_MASTERS-1, so master 0 has priority first after reset.
- Ack counter:
  - Cleared on IDLE -> GRANT.
  - Increments on each ack_i while in GRANT and saturates at HOLD_LIMIT.
  - If no other master is requesting when the limit is reached, the grant is kept and the counter stays saturated. Release then occurs on the next ack_i in which another master is requesting.
- ack_i outside GRANT is ignored.
- The arbiter never drops a grant except on these two conditions. Masters must tolerate a forced release only at an ack boundary.

## Timing
- Reset values: state IDLE, gnt_o = 0, gnt_idx_o = 0, busy_o = 0, cyc_o = 0, last = NUM_MASTERS-1, ack counter = 0.
- Grant latency: cyc_i rises before edge t; gnt_o and busy_o are valid after edge t. cyc_o follows cyc_i combinationally in the same cycle.
- Release: the releasing condition is sampled at edge t; gnt_o = 0 after edge t. The earliest new grant is after edge t+1.
- Simultaneous requests at the IDLE edge: resolved by the selection rule. Losers keep waiting with no state kept for them beyond last.
- Requests that rise and fall while another master is granted are not remembered.
- rst_i asserted mid-grant: all outputs go to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset: assert rst_i mid-grant with cyc_i = 4'b0001 -> gnt_o = 0, cyc_o = 0 immediately. After release, master 0 is granted one edge later.
- Round-robin, N = 4, cyc_i held at 4'b1111, each master dropping cyc for one cycle after its grant -> grants in order 0, 1, 2, 3, 0, with an idle cycle between each.
- Fixed priority (RR_MODE = 0), cyc_i = 4'b1010 -> master 1 granted. When master 1 releases while master 3 still requests -> master 3 granted after one idle cycle.
- Hold limit = 3, master 0 is issuing a long burst and master 2 requests:
  - Three ack_i pulses -> gnt_o drops the edge after the third ack, then gnt_o = 4'b0100 two edges after that ack.
- Hold limit = 3 with no competing master: five acks -> grant to master 0 is retained. Master 1 then requests and the next ack -> release.
- cyc_o gating: master 2 granted, cyc_i[0] toggling -> cyc_o tracks only cyc_i[2]. ack_i pulses while IDLE -> no state change.

Source files
------------

// File: rtl/wb_arbiter_rr.sv
// N-master Wishbone bus arbiter: fixed-priority or round-robin grant with an
// optional ack-count hold limit and a mandatory idle cycle between grants.
module wb_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int RR_MODE     = 1,
  parameter int HOLD_LIMIT  = 0,
  localparam int IDXW       = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_MASTERS-1:0] cyc_i,
  input  logic                   ack_i,
  output logic                   cyc_o,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [IDXW-1:0]        gnt_idx_o,
  output logic                   busy_o
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          state;
  logic [IDXW-1:0] last_q;
  logic [7:0]      ack_cnt;
  logic [IDXW-1:0] winner;
  logic            others_req;
  logic            hold_hit;

  // Winner scan: RR starts one past the last winner and wraps; fixed starts at 0.
  always_comb begin
    int   cand;
    logic found;
    // NOTE: every combinational output gets a default first so no latch is inferred.
    winner = last_q;
    found  = 1'b0;
    cand   = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = (RR_MODE != 0) ? int'(last_q) + 1 + i : i;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (!found && cyc_i[IDXW'(cand)]) begin
        winner = IDXW'(cand);
        found  = 1'b1;
      end
    end
  end

  // gnt_o is one-hot while granted and zero when idle, so masking gives both terms.
  assign cyc_o      = |(cyc_i & gnt_o);
  assign others_req = |(cyc_i & ~gnt_o);
  assign hold_hit   = (HOLD_LIMIT > 0) && ack_i && others_req &&
                      (({1'b0, ack_cnt} + 9'd1) >= 9'(HOLD_LIMIT));

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      gnt_o     <= '0;
      gnt_idx_o <= '0;
      busy_o    <= 1'b0;
      last_q    <= IDXW'(NUM_MASTERS - 1);
      ack_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|cyc_i) begin
            state     <= S_GRANT;
            gnt_o     <= NUM_MASTERS'(1) << winner;
            gnt_idx_o <= winner;
            busy_o    <= 1'b1;
            last_q    <= winner;
            ack_cnt   <= '0;
          end
        end
        S_GRANT: begin
          if (!cyc_o || hold_hit) begin
            state  <= S_IDLE;
            gnt_o  <= '0;
            busy_o <= 1'b0;
          end else if (ack_i && (HOLD_LIMIT > 0) && (ack_cnt < 8'(HOLD_LIMIT))) begin
            ack_cnt <= ack_cnt + 8'd1;
          end
        end
        default: begin
          state  <= S_IDLE;
          gnt_o  <= '0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
